// File: rtl/serial_adder_pkg.sv
// ---------------------------------------------------------------------------
// serial_adder_pkg : shared state encoding and sizing helper for serial_adder
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package serial_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // The counter must hold WIDTH itself after the final shift without wrapping.
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/serial_adder_fulladder.sv
// ---------------------------------------------------------------------------
// fulladder : 1-bit full adder cell (a + b + c -> sum, carry)
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fulladder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b ^ c;
  assign carry = (a & b) | (c & (a ^ b));

endmodule

`default_nettype wire

// File: rtl/serial_adder.sv
// ---------------------------------------------------------------------------
// serial_adder : bit-serial WIDTH-bit adder, LSB first, one fulladder cell
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int             CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state;
  state_t           state_next;
  logic             load;
  logic             shift;
  logic             last;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] result;
  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic             fa_sum;
  logic             fa_carry;

  fulladder u_fulladder (
    .a     (sa[0]),
    .b     (sb[0]),
    .c     (carry),
    .sum   (fa_sum),
    .carry (fa_carry)
  );

  assign last = (cnt == LAST_BIT);
  assign busy = (state == ST_SHIFT);
  assign done = (state == ST_DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    shift      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        shift = 1'b1;
        if (last) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        // A start in the done cycle chains straight into the next add.
        if (start) begin
          load       = 1'b1;
          state_next = ST_SHIFT;
        end else begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sa     <= '0;
      sb     <= '0;
      result <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      sum    <= '0;
      cout   <= 1'b0;
    end else if (load) begin
      sa     <= a;
      sb     <= b;
      carry  <= cin;
      cnt    <= '0;
      result <= '0;
    end else if (shift) begin
      sa     <= sa >> 1;
      sb     <= sb >> 1;
      carry  <= fa_carry;
      cnt    <= cnt + CNT_W'(1);
      result <= {fa_sum, result[WIDTH-1:1]};
      // Publish on the final shift so sum/cout are already valid while done is high.
      if (last) begin
        sum  <= {fa_sum, result[WIDTH-1:1]};
        cout <= fa_carry;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_serial_adder.sv
// ---------------------------------------------------------------------------
// tb_serial_adder : checks 4-bit and 16-bit serial_adder builds against a + b + cin
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst4 = 1'b0, start4 = 1'b0, cin4 = 1'b0;
  logic [3:0]  a4 = '0, b4 = '0;
  logic        busy4, done4, cout4;
  logic [3:0]  sum4;

  logic        rst16 = 1'b0, start16 = 1'b0, cin16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        busy16, done16, cout16;
  logic [15:0] sum16;

  int checks = 0;
  int errors = 0;
  logic [32:0] prev4  = '0;
  logic [32:0] prev16 = '0;

  serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .reset(rst4), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
  );

  serial_adder #(.WIDTH(16)) dut16 (
    .clk(clk), .reset(rst16), .start(start16), .a(a16), .b(b16), .cin(cin16),
    .busy(busy16), .done(done16), .sum(sum16), .cout(cout16)
  );

  task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic get_busy(input bit wide);
    return wide ? busy16 : busy4;
  endfunction

  function automatic logic get_done(input bit wide);
    return wide ? done16 : done4;
  endfunction

  function automatic logic [32:0] get_res(input bit wide);
    return wide ? {16'b0, cout16, sum16} : {28'b0, cout4, sum4};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit wide, input logic st, input logic [31:0] av,
                       input logic [31:0] bv, input logic cv);
    if (wide) begin
      start16 = st; a16 = av[15:0]; b16 = bv[15:0]; cin16 = cv;
    end else begin
      start4 = st; a4 = av[3:0]; b4 = bv[3:0]; cin4 = cv;
    end
  endtask

  // Issues one add starting in the current cycle; returns in the done cycle.
  task automatic run_add(input bit wide, input logic [31:0] av, input logic [31:0] bv,
                         input logic cv, input bit poke);
    int          w;
    int          n;
    int          nbusy;
    bit          seen;
    logic [31:0] mask;
    logic [32:0] exp;
    logic [32:0] prev;
    w    = wide ? 16 : 4;
    mask = wide ? 32'h0000_FFFF : 32'h0000_000F;
    exp  = 33'(av & mask) + 33'(bv & mask) + 33'(cv);
    prev = wide ? prev16 : prev4;
    drive(wide, 1'b1, av, bv, cv);
    tick();
    drive(wide, 1'b0, ~av, ~bv, ~cv);
    chk("busy_after_accept", {32'b0, get_busy(wide)}, 33'd1);
    chk("done_low_in_shift", {32'b0, get_done(wide)}, 33'd0);
    chk("sum_held_in_shift", get_res(wide), prev);
    n = 0; nbusy = 0; seen = 1'b0;
    while (n < w + 4 && !seen) begin
      if (get_busy(wide)) nbusy++;
      tick();
      n++;
      if (poke && n == 1) drive(wide, 1'b1, 32'h7, 32'h7, 1'b0);
      if (poke && n == 2) drive(wide, 1'b0, 32'h7, 32'h7, 1'b0);
      if (get_done(wide)) seen = 1'b1;
    end
    chk("done_seen", {32'b0, seen}, 33'd1);
    chk("latency", 33'(n), 33'(w));
    chk("busy_cycles", 33'(nbusy), 33'(w));
    chk("result", get_res(wide), exp);
    if (wide) prev16 = exp; else prev4 = exp;
  endtask

  task automatic idle_check(input bit wide, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      tick();
      chk("no_extra_done", {32'b0, get_done(wide)}, 33'd0);
      chk("idle_not_busy", {32'b0, get_busy(wide)}, 33'd0);
      chk("result_held", get_res(wide), wide ? prev16 : prev4);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    int dones;
    logic [31:0] ra, rb;
    logic        rc;

    // Reset held two cycles with start asserted: nothing may begin.
    tick();
    rst4 = 1'b1; rst16 = 1'b1;
    drive(1'b0, 1'b1, 32'hF, 32'hF, 1'b1);
    drive(1'b1, 1'b1, 32'hFFFF, 32'hFFFF, 1'b1);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_busy4", {32'b0, busy4}, 33'd0);
      chk("rst_done4", {32'b0, done4}, 33'd0);
      chk("rst_res4", get_res(1'b0), 33'd0);
      chk("rst_busy16", {32'b0, busy16}, 33'd0);
      chk("rst_res16", get_res(1'b1), 33'd0);
    end
    rst4 = 1'b0; rst16 = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
    tick();
    chk("post_rst_busy4", {32'b0, busy4}, 33'd0);
    chk("post_rst_busy16", {32'b0, busy16}, 33'd0);

    // Directed 4-bit cases.
    run_add(1'b0, 32'h3, 32'h5, 1'b0, 1'b0);
    idle_check(1'b0, 2);
    run_add(1'b0, 32'hF, 32'h1, 1'b1, 1'b0);
    idle_check(1'b0, 2);
    run_add(1'b0, 32'h3, 32'h4, 1'b0, 1'b1);
    idle_check(1'b0, 8);
    run_add(1'b0, 32'h1, 32'h1, 1'b0, 1'b0);
    run_add(1'b0, 32'h2, 32'h3, 1'b0, 1'b0);
    idle_check(1'b0, 1);

    // Abort a 16-bit add mid-flight with reset.
    drive(1'b1, 1'b1, 32'hFFFF, 32'h0001, 1'b0);
    tick();
    drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
    repeat (5) tick();
    rst16 = 1'b1;
    tick();
    rst16 = 1'b0;
    chk("abort_busy", {32'b0, busy16}, 33'd0);
    chk("abort_done", {32'b0, done16}, 33'd0);
    chk("abort_res", get_res(1'b1), 33'd0);
    prev16 = '0;
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done16) dones++;
    end
    chk("abort_no_done", 33'(dones), 33'd0);
    run_add(1'b1, 32'h1234, 32'h4321, 1'b1, 1'b0);
    idle_check(1'b1, 1);

    // Exhaustive 4-bit sweep, all back-to-back.
    for (int ia = 0; ia < 16; ia++)
      for (int ib = 0; ib < 16; ib++)
        for (int ic = 0; ic < 2; ic++)
          run_add(1'b0, 32'(ia), 32'(ib), ic[0], 1'b0);
    idle_check(1'b0, 1);

    // Random 16-bit operands, back-to-back.
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = $urandom;
      rc = $urandom_range(0, 1) == 1;
      run_add(1'b1, ra, rb, rc, 1'b0);
    end
    run_add(1'b1, 32'hFFFF, 32'hFFFF, 1'b1, 1'b0);
    idle_check(1'b1, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
